// File: rtl/cla_pkg.sv
// Shared constants for the sequential carry-lookahead adder: nibble width,
// FSM state encoding and the nibble-count helper.
package cla_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla_nibble.sv
// Combinational 4-bit carry-lookahead slice: per-bit propagate/generate and
// fully flattened carries C[4:0], so no carry ripples inside the nibble.
module cla_nibble
  import cla_pkg::*;
(
  input  logic [NIB_W-1:0] a_n,
  input  logic [NIB_W-1:0] b_n,
  input  logic             c0,
  output logic [NIB_W-1:0] s,
  output logic [NIB_W:0]   c
);

  logic [NIB_W-1:0] w_p;
  logic [NIB_W-1:0] w_g;

  assign w_p = a_n ^ b_n;
  assign w_g = a_n & b_n;

  assign c[0] = c0;
  assign c[1] = w_g[0] | (w_p[0] & c0);
  assign c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c0);
  assign c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & c0);
  assign c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & c0);

  assign s = w_p ^ c[NIB_W-1:0];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle WIDTH-bit adder resolving one nibble per cycle through a shared
// lookahead slice. Optional subtract mode under macro CLA_SEQ_ADDER_SUB_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// RUN   | one nibble per cycle, group carry held in r_carry
// DONE  | result held with out_valid high until out_ready
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [NIB_W-1:0] w_a_n;
  logic [NIB_W-1:0] w_b_n;
  logic [NIB_W-1:0] w_s;
  logic [NIB_W:0]   w_c;
  logic             w_last;
  logic             w_unused;

  assign w_a_n  = r_a[{r_idx, 2'b00} +: NIB_W];
  assign w_b_n  = r_b[{r_idx, 2'b00} +: NIB_W];
  assign w_last = (r_idx == IDX_W'(NIB - 1));
  // Only the group carry and the carry into the MSB matter at this level.
  assign w_unused = ^w_c[2:0];

  cla_nibble u_nibble (
    .a_n (w_a_n),
    .b_n (w_b_n),
    .c0  (r_carry),
    .s   (w_s),
    .c   (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_a        <= a;
`ifdef CLA_SEQ_ADDER_SUB_EN
            r_b        <= sub ? ~b : b;
            r_carry    <= sub ? 1'b1 : cin;
`else
            r_b        <= b;
            r_carry    <= cin;
`endif
            r_idx      <= '0;
            r_sum      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: NIB_W] <= w_s;
          r_carry <= w_c[NIB_W];
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_cout      <= w_c[NIB_W];
            r_ovf       <= w_c[NIB_W-1] ^ w_c[NIB_W];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Scoreboard bench for cla_seq_adder (WIDTH=16); exercises subtract mode when
// CLA_SEQ_ADDER_SUB_EN is defined.
module tb_cla_seq_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef CLA_SEQ_ADDER_SUB_EN
  logic             sub = 1'b0;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Reference: wide addition, overflow from operand/result sign bits.
  function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                 input logic mc, input logic ms);
    exp_t             e;
    logic [WIDTH-1:0] bb;
    logic             cc;
    logic [WIDTH:0]   full;
    bb   = ms ? ~mb : mb;
    cc   = ms ? 1'b1 : mc;
    full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (ma[WIDTH-1] == bb[WIDTH-1]) && (e.sum[WIDTH-1] != ma[WIDTH-1]);
    return e;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input logic ts, input int hold, input string tag);
    exp_t e;
    int   lat;
    logic [WIDTH-1:0] h_sum;
    logic h_cout, h_ovf;
    @(negedge clk);
    chk({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    a = ta; b = tb_v; cin = tc;
`ifdef CLA_SEQ_ADDER_SUB_EN
    sub = ts;
`endif
    sb_q.push_back(model(ta, tb_v, tc, ts));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = ~tc;
`ifdef CLA_SEQ_ADDER_SUB_EN
    sub = ~ts;
`endif
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
      chk({tag, "_in_ready_run"}, in_ready, 0);
      in_valid = 1'b1;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, NIB);
    e = sb_q.pop_front();
    chk({tag, "_sum"}, sum, e.sum);
    chk({tag, "_cout"}, cout, e.cout);
    chk({tag, "_ovf"}, ovf, e.ovf);
    h_sum = sum; h_cout = cout; h_ovf = ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      chk({tag, "_hold_sum"}, sum, h_sum);
      chk({tag, "_hold_flags"}, {cout, ovf}, {h_cout, h_ovf});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_release_valid"}, out_valid, 0);
    chk({tag, "_release_in_ready"}, in_ready, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_flags", {cout, ovf}, 0);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, "basic");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, "wrap");
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0, 0, "cin_only");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, "ovf_pos");
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0, "ovf_neg");
    run_op(16'hA5C3, 16'h5A3D, 1'b1, 1'b0, 10, "backpressure");

    // Reset on the second RUN cycle discards the partial result.
    @(negedge clk);
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, "after_rst");

    for (int i = 0; i < 6; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0, 0, "rand_add");

`ifdef CLA_SEQ_ADDER_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0, "sub_borrow");
    run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, "sub_noborrow");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, "sub_ovf");
    for (int i = 0; i < 4; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1, 0, "rand_sub");
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
